fpu_exception_sequencer: RTL

//   Issue/result stage directly downstream of the FPU_8 exception check. Accepts one

---
 rtl/fpu_exception_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fpu_exception_sequencer.sv
// ============================================================================
// Module   : fpu_exception_sequencer
// Purpose  : Issue/result stage behind the FPU exception check. Takes one
//            operation per valid/ready handshake. An excepting operation gets
//            its IEEE-style special result here, without starting the core.
//            A clean operation launches the multi-cycle arithmetic core and
//            waits for it under a timeout. Either way, the result is held
//            until the consumer accepts it.
// Ports    : clk, rst_n              - clock (rising edge), async active-low reset
//            in_valid/in_ready       - operation handshake
//            fp_operation, op_a/op_b - operation code and operands
//            op_is_exception/fp_exce - exception flag and code for the operands
//            core_start/op/a/b       - launch pulse and latched operation to core
//            core_done/core_result   - core completion pulse and result
//            out_valid/out_ready     - result handshake
//            result/result_exce      - final result and its exception code
//            out_timeout             - result came from the timeout path
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_exception_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  QNAN_VALUE     = 8'h7C,
  parameter logic [6:0]  INF_MAG        = 7'h78,
  parameter logic [2:0]  NO_EXCE        = 3'd0,
  parameter logic [2:0]  QNAN_EXCE      = 3'd1,
  parameter logic [2:0]  INF_EXCE       = 3'd2,
  parameter logic [2:0]  ZERO_DIV_EXCE  = 3'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] fp_operation,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       op_is_exception,
  input  logic [2:0] fp_exce,
  output logic       core_start,
  output logic [1:0] core_op,
  output logic [7:0] core_a,
  output logic [7:0] core_b,
  input  logic       core_done,
  input  logic [7:0] core_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic [2:0] result_exce,
  output logic       out_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] count;

  // Special result for an excepting operation. NaN and infinity operands
  // both collapse to the canonical quiet NaN; a divide by zero yields a
  // signed infinity, except 0/0 which is itself an invalid operation.
  logic [7:0] special_result;
  logic [2:0] special_exce;

  always_comb begin
    special_result = QNAN_VALUE;
    special_exce   = fp_exce;
    if (fp_exce == ZERO_DIV_EXCE) begin
      if (op_a[6:0] == 7'd0) begin
        special_exce = QNAN_EXCE;
      end else begin
        special_result = {op_a[7] ^ op_b[7], INF_MAG};
        special_exce   = ZERO_DIV_EXCE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      core_start  <= 1'b0;
      core_op     <= 2'd0;
      core_a      <= 8'd0;
      core_b      <= 8'd0;
      out_valid   <= 1'b0;
      out_timeout <= 1'b0;
      result      <= 8'd0;
      result_exce <= NO_EXCE;
      count       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            core_op  <= fp_operation;
            core_a   <= op_a;
            core_b   <= op_b;
            in_ready <= 1'b0;
            if (op_is_exception) begin
              result      <= special_result;
              result_exce <= special_exce;
              out_valid   <= 1'b1;
              state       <= S_HOLD;
            end else begin
              core_start <= 1'b1;
              state      <= S_LAUNCH;
            end
          end
        end

        // core_start is high for this single cycle; a core_done seen here
        // cannot belong to the operation just launched and is dropped.
        S_LAUNCH: begin
          core_start <= 1'b0;
          count      <= '0;
          state      <= S_WAIT;
        end

        // A completion in the final counted cycle beats the timeout.
        S_WAIT: begin
          count <= count + CW'(1);
          if (core_done) begin
            result      <= core_result;
            result_exce <= NO_EXCE;
            out_valid   <= 1'b1;
            state       <= S_HOLD;
          end else if (count == COUNT_LAST) begin
            result      <= QNAN_VALUE;
            result_exce <= QNAN_EXCE;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_timeout <= 1'b0;
            in_ready    <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
